alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit_if.sv | 38 +++
 rtl/alu_exec_unit.sv | 195 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle for alu_exec_unit: valid/ready op issue, result and flags.
// `ALU_OVERFLOW_EN adds the overflow flag.
interface alu_exec_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_SIZE    = 6
);
  logic                  op_valid;
  logic                  op_ready;
  logic [OP_SIZE-1:0]    Operation;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid;
  logic                  zero;
  logic                  branch_taken;
  logic                  busy;
  logic                  div_by_zero;
`ifdef ALU_OVERFLOW_EN
  logic                  overflow;
`endif

  modport master (
    output op_valid, Operation, A, B, shamt,
    input  op_ready, result, result_valid, zero, branch_taken, busy, div_by_zero
`ifdef ALU_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  op_valid, Operation, A, B, shamt,
    output op_ready, result, result_valid, zero, branch_taken, busy, div_by_zero
`ifdef ALU_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered single-cycle ops plus iterative signed MULT/DIV into HI/LO.
// `ALU_OVERFLOW_EN enables the registered ADD/SUB signed-overflow flag.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_SIZE    = 6,
  parameter int CNT_WIDTH  = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_unit_if.slave  bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH-1);

  localparam logic [OP_SIZE-1:0] ALU_ADD  = OP_SIZE'(0);
  localparam logic [OP_SIZE-1:0] ALU_SUB  = OP_SIZE'(1);
  localparam logic [OP_SIZE-1:0] ALU_AND  = OP_SIZE'(2);
  localparam logic [OP_SIZE-1:0] ALU_OR   = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] ALU_NOR  = OP_SIZE'(4);
  localparam logic [OP_SIZE-1:0] ALU_SLT  = OP_SIZE'(5);
  localparam logic [OP_SIZE-1:0] ALU_SLL  = OP_SIZE'(6);
  localparam logic [OP_SIZE-1:0] ALU_SRL  = OP_SIZE'(7);
  localparam logic [OP_SIZE-1:0] ALU_LUI  = OP_SIZE'(8);
  localparam logic [OP_SIZE-1:0] ALU_BEQ  = OP_SIZE'(9);
  localparam logic [OP_SIZE-1:0] ALU_BGEZ = OP_SIZE'(10);
  localparam logic [OP_SIZE-1:0] ALU_MFHI = OP_SIZE'(11);
  localparam logic [OP_SIZE-1:0] ALU_MFLO = OP_SIZE'(12);
  localparam logic [OP_SIZE-1:0] ALU_MULT = OP_SIZE'(13);
  localparam logic [OP_SIZE-1:0] ALU_DIV  = OP_SIZE'(14);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               state, state_nx;
  logic [CNT_WIDTH-1:0] cnt;
  logic [2*W-1:0]       acc;      // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
  logic [W-1:0]         mag_b;    // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic [W-1:0]         a_sav, hi, lo;
  logic                 neg_p, neg_r, is_div, b_zero;

  logic [W-1:0] res_q;
  logic         rv_q, zero_q, bt_q, dbz_q;

  logic         accept, is_md;
  logic [W-1:0] mag_a_in, mag_b_in, sum, diff;
  logic [W-1:0] res_c;
  logic         zero_c, bt_c, known;

  assign bus.op_ready     = (state == S_IDLE);
  assign bus.busy         = (state != S_IDLE);
  assign bus.result       = res_q;
  assign bus.result_valid = rv_q;
  assign bus.zero         = zero_q;
  assign bus.branch_taken = bt_q;
  assign bus.div_by_zero  = dbz_q;

  assign accept   = bus.op_valid && bus.op_ready;
  assign is_md    = (bus.Operation == ALU_MULT) || (bus.Operation == ALU_DIV);
  assign mag_a_in = bus.A[W-1] ? -bus.A : bus.A;
  assign mag_b_in = bus.B[W-1] ? -bus.B : bus.B;
  assign sum      = bus.A + bus.B;
  assign diff     = bus.A - bus.B;

  always_comb begin
    res_c = '0;
    bt_c  = 1'b0;
    known = 1'b1;
    case (bus.Operation)
      ALU_ADD:  res_c = sum;
      ALU_SUB:  res_c = diff;
      ALU_AND:  res_c = bus.A & bus.B;
      ALU_OR:   res_c = bus.A | bus.B;
      ALU_NOR:  res_c = ~(bus.A | bus.B);
      ALU_SLT:  res_c = {{(W-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      ALU_SLL:  res_c = bus.B << bus.shamt;
      ALU_SRL:  res_c = bus.B >> bus.shamt;
      ALU_LUI:  res_c = {bus.B[15:0], {(W-16){1'b0}}};
      ALU_BEQ:  begin res_c = diff; bt_c = (bus.A == bus.B); end
      ALU_BGEZ: begin res_c = bus.A; bt_c = ~bus.A[W-1]; end
      ALU_MFHI: res_c = hi;
      ALU_MFLO: res_c = lo;
      default:  known = 1'b0;
    endcase
    zero_c = known && (res_c == '0);
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_c, ovf_q;
  assign bus.overflow = ovf_q;
  always_comb begin
    ovf_c = 1'b0;
    if (bus.Operation == ALU_ADD)
      ovf_c = (bus.A[W-1] == bus.B[W-1]) && (sum[W-1] != bus.A[W-1]);
    else if (bus.Operation == ALU_SUB)
      ovf_c = (bus.A[W-1] != bus.B[W-1]) && (diff[W-1] != bus.A[W-1]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ovf_q <= 1'b0;
    else if (state == S_FIX)    ovf_q <= 1'b0;
    else if (accept && !is_md)  ovf_q <= ovf_c;
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) begin
        if (bus.Operation == ALU_MULT)     state_nx = S_MUL;
        else if (bus.Operation == ALU_DIV) state_nx = S_DIV;
      end
      S_MUL, S_DIV: if (cnt == LAST) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // One shift-add / restoring-subtract step per cycle on the shared accumulator.
  logic [W:0]     mul_sum, div_tr;
  logic [W-1:0]   div_sh;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_b} : '0);
  assign div_sh   = {acc[2*W-2:W], acc[W-1]};
  assign div_tr   = {1'b0, div_sh} - {1'b0, mag_b};
  assign prod_fix = neg_p ? -acc : acc;
  assign quo_fix  = neg_p ? -acc[W-1:0] : acc[W-1:0];
  assign rem_fix  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mag_b  <= '0;
      a_sav  <= '0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      res_q  <= '0;
      rv_q   <= 1'b0;
      zero_q <= 1'b0;
      bt_q   <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      state <= state_nx;
      rv_q  <= 1'b0;
      dbz_q <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          cnt <= '0;
          if (bus.Operation == ALU_MULT) begin
            acc    <= {{W{1'b0}}, mag_b_in};
            mag_b  <= mag_a_in;
            neg_p  <= bus.A[W-1] ^ bus.B[W-1];
            is_div <= 1'b0;
          end else if (bus.Operation == ALU_DIV) begin
            acc    <= {{W{1'b0}}, mag_a_in};
            mag_b  <= mag_b_in;
            neg_p  <= bus.A[W-1] ^ bus.B[W-1];
            neg_r  <= bus.A[W-1];
            b_zero <= (bus.B == '0);
            a_sav  <= bus.A;
            is_div <= 1'b1;
          end else begin
            res_q  <= res_c;
            zero_q <= zero_c;
            bt_q   <= bt_c;
            rv_q   <= 1'b1;
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[W-1:1]};
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        S_DIV: begin
          acc <= div_tr[W] ? {div_sh, acc[W-2:0], 1'b0} : {div_tr[W-1:0], acc[W-2:0], 1'b1};
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        S_FIX: begin
          if (!is_div)     begin hi <= prod_fix[2*W-1:W]; lo <= prod_fix[W-1:0]; end
          else if (b_zero) begin hi <= a_sav; lo <= '1; end
          else             begin hi <= rem_fix; lo <= quo_fix; end
          res_q  <= '0;
          zero_q <= 1'b1;
          bt_q   <= 1'b0;
          rv_q   <= 1'b1;
          dbz_q  <= is_div && b_zero;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Random + directed bench for alu_exec_unit against a cycle-level arithmetic model.
module tb_alu_exec_unit;
  localparam logic [5:0] ADD=0, SUB=1, AND_=2, OR_=3, NOR_=4, SLT=5, SLL=6, SRL=7,
                         LUI=8, BEQ=9, BGEZ=10, MFHI=11, MFLO=12, MULT=13, DIV=14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.DATA_WIDTH(32), .OP_SIZE(6)) ifc();
  alu_exec_unit #(.DATA_WIDTH(32), .OP_SIZE(6), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: ops counted in cycles remaining, results from plain signed arithmetic.
  int          busy_left = 0;
  logic [31:0] mhi = 0, mlo = 0, phi = 0, plo = 0, e_res = 0;
  bit          pdbz, e_rv, e_zero, e_bt, e_dbz, e_ovf;

  task automatic model_accept(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh);
    longint p, q, r, s;
    bit known = 1;
    e_ovf = 0; e_bt = 0; e_res = 0;
    case (op)
      ADD:  begin s = longint'($signed(a)) + longint'($signed(b)); e_res = a + b;
                  e_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      SUB:  begin s = longint'($signed(a)) - longint'($signed(b)); e_res = a - b;
                  e_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      AND_: e_res = a & b;
      OR_:  e_res = a | b;
      NOR_: e_res = ~(a | b);
      SLT:  e_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLL:  e_res = b << sh;
      SRL:  e_res = b >> sh;
      LUI:  e_res = b * 32'h10000;
      BEQ:  begin e_res = a - b; e_bt = (a == b); end
      BGEZ: begin e_res = a; e_bt = ($signed(a) >= 0); end
      MFHI: e_res = mhi;
      MFLO: e_res = mlo;
      MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        phi = p[63:32]; plo = p[31:0]; pdbz = 0; busy_left = 33;
      end
      DIV: begin
        if (b == 0) begin phi = a; plo = 32'hFFFFFFFF; pdbz = 1; end
        else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          phi = r[31:0]; plo = q[31:0]; pdbz = 0;
        end
        busy_left = 33;
      end
      default: known = 0;
    endcase
    if (op != MULT && op != DIV) begin
      e_rv = 1;
      e_zero = known && (e_res == 0);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      busy_left = 0; mhi = 0; mlo = 0; e_res = 0;
      e_rv = 0; e_zero = 0; e_bt = 0; e_dbz = 0; e_ovf = 0;
    end else begin
      e_rv = 0; e_dbz = 0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          mhi = phi; mlo = plo;
          e_rv = 1; e_res = 0; e_zero = 1; e_bt = 0; e_ovf = 0; e_dbz = pdbz;
        end
      end else if (ifc.op_valid) begin
        model_accept(ifc.Operation, ifc.A, ifc.B, ifc.shamt);
      end
    end
  end

  // Compare every cycle while out of reset.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("op_ready", 32'(ifc.op_ready), 32'(busy_left == 0));
      chk("busy", 32'(ifc.busy), 32'(busy_left > 0));
      chk("result_valid", 32'(ifc.result_valid), 32'(e_rv));
      chk("div_by_zero", 32'(ifc.div_by_zero), 32'(e_dbz));
      if (e_rv) begin
        chk("result", ifc.result, e_res);
        chk("zero", 32'(ifc.zero), 32'(e_zero));
        chk("branch_taken", 32'(ifc.branch_taken), 32'(e_bt));
`ifdef ALU_OVERFLOW_EN
        chk("overflow", 32'(ifc.overflow), 32'(e_ovf));
`endif
      end
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output int waited);
    @(negedge clk);
    ifc.op_valid = 1; ifc.Operation = op; ifc.A = a; ifc.B = b; ifc.shamt = sh;
    waited = 0;
    while (!ifc.op_ready && waited < 100) begin @(negedge clk); waited++; end
    if (waited >= 100) chk("issue_timeout", 32'(waited), 32'd0);
    @(posedge clk);
  endtask

  task automatic go(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    issue(op, a, b, 5'd0, w);
    @(negedge clk);
    ifc.op_valid = 0;
  endtask

  // Runs a MULT/DIV to completion; returns with result_valid expected high.
  task automatic go_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string nm);
    int n = 0;
    go(op, a, b);
    while (ifc.busy && n < 60) begin n++; @(negedge clk); end
    chk({nm, "_busy_cycles"}, 32'(n), 32'd33);
    chk({nm, "_done_rv"}, 32'(ifc.result_valid), 32'd1);
    chk({nm, "_done_result"}, ifc.result, 32'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 10));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int w;
    ifc.op_valid = 0; ifc.Operation = 0; ifc.A = 0; ifc.B = 0; ifc.shamt = 0;
    repeat (2) @(negedge clk);
    chk("rst_result", ifc.result, 32'd0);
    chk("rst_rv", 32'(ifc.result_valid), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_ready", 32'(ifc.op_ready), 32'd1);
    chk("rst_flags", {29'd0, ifc.zero, ifc.branch_taken, ifc.div_by_zero}, 32'd0);
    rst_n = 1;

    go(ADD, 32'h7FFFFFFF, 32'd1);
    chk("add_wrap", ifc.result, 32'h80000000);
`ifdef ALU_OVERFLOW_EN
    chk("add_ovf", 32'(ifc.overflow), 32'd1);
`endif
    @(negedge clk);
    chk("add_rv_pulse", 32'(ifc.result_valid), 32'd0);

    go_md(MULT, 32'hFFFFFFFD, 32'd7, "mult");
    go(MFLO, 0, 0); chk("mult_lo", ifc.result, 32'hFFFFFFEB);
    go(MFHI, 0, 0); chk("mult_hi", ifc.result, 32'hFFFFFFFF);

    go_md(DIV, 32'hFFFFFFF9, 32'd2, "div");
    go(MFLO, 0, 0); chk("div_lo", ifc.result, 32'hFFFFFFFD);
    go(MFHI, 0, 0); chk("div_hi", ifc.result, 32'hFFFFFFFF);

    go_md(DIV, 32'd5, 32'd0, "div0");
    chk("div0_flag", 32'(ifc.div_by_zero), 32'd1);
    go(MFLO, 0, 0); chk("div0_lo", ifc.result, 32'hFFFFFFFF);
    go(MFHI, 0, 0); chk("div0_hi", ifc.result, 32'd5);

    go_md(DIV, 32'h80000000, 32'hFFFFFFFF, "divmin");
    go(MFLO, 0, 0); chk("divmin_lo", ifc.result, 32'h80000000);
    go(MFHI, 0, 0); chk("divmin_hi", ifc.result, 32'd0);

    go(BEQ, 32'h1234, 32'h1234);
    chk("beq_zero", 32'(ifc.zero), 32'd1);
    chk("beq_taken", 32'(ifc.branch_taken), 32'd1);
    go(BGEZ, 32'd0, 32'd0);          chk("bgez0", 32'(ifc.branch_taken), 32'd1);
    go(BGEZ, 32'h80000000, 32'd0);   chk("bgezneg", 32'(ifc.branch_taken), 32'd0);
    go(63, 32'h5, 32'h6);            chk("unknown_res", ifc.result, 32'd0);

    // MFHI held valid across a MULT: accepted only once the unit frees up.
    issue(MULT, 32'h12345678, 32'h100, 5'd0, w);
    issue(MFHI, 0, 0, 5'd0, w);
    chk("held_wait", 32'(w), 32'd33);
    @(negedge clk); ifc.op_valid = 0;
    chk("held_hi", ifc.result, 32'h12);

    // Reset during busy cycle 10 aborts the MULT and clears HI/LO.
    issue(MULT, 32'hFFFFFFFD, 32'd7, 5'd0, w);
    @(negedge clk); ifc.op_valid = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_busy", 32'(ifc.busy), 32'd0);
    chk("abort_ready", 32'(ifc.op_ready), 32'd1);
    chk("abort_rv", 32'(ifc.result_valid), 32'd0);
    @(negedge clk); rst_n = 1;
    go(MFHI, 0, 0); chk("abort_hi", ifc.result, 32'd0);
    go(MFLO, 0, 0); chk("abort_lo", ifc.result, 32'd0);

    for (int i = 0; i < 400; i++) begin
      int x = $urandom_range(0, 99);
      logic [5:0] op;
      logic [31:0] a = rnd_val();
      logic [31:0] b = rnd_val();
      if (x < 5)       op = MULT;
      else if (x < 10) op = DIV;
      else if (x < 13) op = 6'($urandom_range(15, 63));
      else             op = 6'($urandom_range(0, 12));
      if (op == BEQ && $urandom_range(0, 1) == 1) b = a;
      issue(op, a, b, 5'($urandom_range(0, 31)), w);
      if ($urandom_range(0, 3) == 0) begin @(negedge clk); ifc.op_valid = 0; end
    end
    @(negedge clk); ifc.op_valid = 0;
    repeat (40) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
